// File: rtl/dmac_pkg.sv
// Shared types and constants for the DMAC read-address burst path.
package dmac_pkg;
  localparam int BEAT_BYTES     = 4;
  localparam int BOUNDARY_BYTES = 4096;
  localparam int AR_ADDR_W      = 32;

  typedef enum logic {S_IDLE, S_REQ} ar_state_t;

  typedef struct packed {
    logic [3:0]           len;
    logic [AR_ADDR_W-1:0] addr;
  } ar_req_t;
endpackage

// File: rtl/dmac_burst_len_calc.sv
// Beats for the next burst: min of MAX_BEATS, words left, and words to the 4 KB edge.
module dmac_burst_len_calc
  import dmac_pkg::*;
#(
  parameter int LEN_WIDTH = 16,
  parameter int MAX_BEATS = 16
) (
  input  logic [11:0]          addr_off_i,
  input  logic [LEN_WIDTH-1:0] remaining_i,
  output logic [4:0]           beats_o
);
  localparam int CW = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  logic [12:0]   bnd_b;
  logic [CW-1:0] rem_w, bnd_w, max_w, m;

  always_comb begin
    bnd_b = 13'(BOUNDARY_BYTES) - {1'b0, addr_off_i};
    rem_w = CW'(remaining_i >> 2);
    bnd_w = CW'(bnd_b[12:2]);
    max_w = CW'(MAX_BEATS);
    m     = max_w;
    if (rem_w < m) m = rem_w;
    if (bnd_w < m) m = bnd_w;
    // Idle/reset state has remaining=0; clamp so req_len never underflows.
    if (m == '0) m = CW'(1);
    beats_o = m[4:0];
  end
endmodule

// File: rtl/dmac_ar_gen.sv
// Per-channel read-address burst generator: splits a transfer into 4 KB-safe bursts.
module dmac_ar_gen
  import dmac_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [LEN_WIDTH-1:0]  byte_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [ADDR_WIDTH+3:0] req_data_o
);
  ar_state_t             state_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, start_addr;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d, start_len, step;
  logic                  busy_q, done_q, valid_q;
  logic [4:0]            beats;
  logic [3:0]            req_len;
  logic                  hs;

  dmac_burst_len_calc #(
    .LEN_WIDTH(LEN_WIDTH),
    .MAX_BEATS(MAX_BEATS)
  ) u_calc (
    .addr_off_i (addr_q[11:0]),
    .remaining_i(rem_q),
    .beats_o    (beats)
  );

  always_comb begin
    start_addr = src_addr_i & ~ADDR_WIDTH'(BEAT_BYTES - 1);
    start_len  = byte_len_i & ~LEN_WIDTH'(BEAT_BYTES - 1);
    step       = LEN_WIDTH'({beats, 2'b00});
    req_len    = 4'(beats - 5'd1);
    hs         = valid_q & req_ready_i;
    addr_d     = addr_q + ADDR_WIDTH'(step);
    rem_d      = rem_q - step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start_i) begin
          if (start_len != '0) begin
            addr_q  <= start_addr;
            rem_q   <= start_len;
            state_q <= S_REQ;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
          end else begin
            done_q <= 1'b1;
          end
        end
        S_REQ: if (hs) begin
          addr_q <= addr_d;
          rem_q  <= rem_d;
          if (rem_d == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign req_valid_o = valid_q;
  // Data comes straight from the registers, so it cannot move while a burst is stalled.
  assign req_data_o  = {req_len, addr_q};
endmodule

// File: tb/tb_dmac_ar_gen.sv
// Bench for dmac_ar_gen: table of transfers with a burst scoreboard plus corner sequences.
module tb_dmac_ar_gen;
  import dmac_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] src_addr_i;
  logic [15:0] byte_len_i;
  logic        busy_o, done_o, req_valid_o, req_ready_i;
  logic [35:0] req_data_o;

  dmac_ar_gen #(.ADDR_WIDTH(32), .LEN_WIDTH(16), .MAX_BEATS(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .src_addr_i(src_addr_i),
    .byte_len_i(byte_len_i), .busy_o(busy_o), .done_o(done_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_data_o(req_data_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [35:0] exp_q[$];
  int          bursts;
  logic [35:0] first_seen;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference burst splitter: walks the transfer word by word limits.
  task automatic model_push(input logic [31:0] a_in, input logic [15:0] l_in);
    logic [31:0] a;
    int r, b, bw;
    a = a_in & 32'hFFFF_FFFC;
    r = int'(l_in & 16'hFFFC);
    while (r > 0) begin
      b = 16;
      if (r / 4 < b) b = r / 4;
      bw = (4096 - int'(a % 4096)) / 4;
      if (bw < b) b = bw;
      exp_q.push_back({4'(b - 1), a});
      a = a + 32'(b * 4);
      r = r - b * 4;
    end
  endtask

  // Scoreboard side: every accepted burst must match the next modelled one.
  always @(negedge clk) begin
    if (!rst && req_valid_o && req_ready_i) begin
      if (bursts == 0) first_seen = req_data_o;
      bursts++;
      if (exp_q.size() == 0) chk("unexpected_burst", {28'd0, req_data_o}, 64'hDEAD);
      else chk("burst_data", {28'd0, req_data_o}, {28'd0, exp_q.pop_front()});
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
    bit          rand_rdy;
    int          nb;
    logic [35:0] first;
  } vec_t;

  vec_t vecs[8];

  task automatic pulse_start(input logic [31:0] a, input logic [15:0] l);
    @(posedge clk); #1;
    start_i = 1'b1; src_addr_i = a; byte_len_i = l;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Waits for done_o, driving ready each cycle; returns 1 if done arrived in budget.
  task automatic wait_done(input bit rand_rdy, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done_o) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      req_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  initial begin
    bit ok;
    logic [35:0] held;
    bit bad;
    rst = 1'b1; start_i = 1'b0; src_addr_i = '0; byte_len_i = '0; req_ready_i = 1'b1;
    bursts = 0; first_seen = '0;

    vecs[0] = '{32'h0000_1000, 16'd64,  1'b0, 1, {4'd15, 32'h0000_1000}};
    vecs[1] = '{32'h0000_1000, 16'd100, 1'b0, 2, {4'd15, 32'h0000_1000}};
    vecs[2] = '{32'h0000_0FF8, 16'd32,  1'b0, 2, {4'd1,  32'h0000_0FF8}};
    vecs[3] = '{32'h0000_0FFC, 16'd8,   1'b0, 2, {4'd0,  32'h0000_0FFC}};
    vecs[4] = '{32'h0000_3F00, 16'd256, 1'b0, 4, {4'd15, 32'h0000_3F00}};
    vecs[5] = '{32'h0000_0003, 16'd7,   1'b0, 1, {4'd0,  32'h0000_0000}};
    vecs[6] = '{32'h0000_0FF8, 16'd32,  1'b1, 2, {4'd1,  32'h0000_0FF8}};
    vecs[7] = '{32'hFFFF_FFF0, 16'd32,  1'b1, 2, {4'd3,  32'hFFFF_FFF0}};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy",  64'(busy_o), 64'd0);
    chk("reset_done",  64'(done_o), 64'd0);
    chk("reset_valid", 64'(req_valid_o), 64'd0);
    chk("reset_data",  64'(req_data_o), 64'd0);

    foreach (vecs[i]) begin
      bursts = 0;
      req_ready_i = 1'b1;
      model_push(vecs[i].addr, vecs[i].len);
      pulse_start(vecs[i].addr, vecs[i].len);
      @(negedge clk);
      chk("latency_valid", {63'd0, req_valid_o}, 64'd1);
      chk("latency_busy",  {63'd0, busy_o}, 64'd1);
      wait_done(vecs[i].rand_rdy, ok);
      chk("done_seen", 64'(ok), 64'd1);
      chk("done_no_valid", 64'(req_valid_o), 64'd0);
      chk("burst_count", 64'(bursts), 64'(vecs[i].nb));
      chk("first_burst", 64'(first_seen), 64'(vecs[i].first));
      @(negedge clk);
      chk("done_one_cycle", 64'(done_o), 64'd0);
      chk("idle_busy", 64'(busy_o), 64'd0);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end

    // Zero-length transfer: immediate done, nothing issued.
    bursts = 0;
    pulse_start(32'h0000_2000, 16'd0);
    @(negedge clk);
    chk("zero_done",  64'(done_o), 64'd1);
    chk("zero_valid", 64'(req_valid_o), 64'd0);
    chk("zero_busy",  64'(busy_o), 64'd0);
    @(negedge clk);
    chk("zero_done_drop", 64'(done_o), 64'd0);
    chk("zero_bursts", 64'(bursts), 64'd0);

    // Stall with a second start while busy.
    bursts = 0;
    req_ready_i = 1'b0;
    model_push(32'h0000_1000, 16'd100);
    pulse_start(32'h0000_1000, 16'd100);
    bad = 1'b0;
    held = {4'd15, 32'h0000_1000};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (req_valid_o !== 1'b1 || req_data_o !== held || busy_o !== 1'b1) bad = 1'b1;
      @(posedge clk); #1;
      start_i = (c == 1);
      src_addr_i = 32'h0000_5000; byte_len_i = 16'd8;
    end
    start_i = 1'b0;
    chk("stall_stable", 64'(bad), 64'd0);
    wait_done(1'b0, ok);
    chk("stall_done", 64'(ok), 64'd1);
    chk("stall_bursts", 64'(bursts), 64'd2);
    chk("stall_queue", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);

    // Reset during the second burst of a three-burst transfer.
    bursts = 0;
    req_ready_i = 1'b1;
    model_push(32'h0000_1000, 16'd192);
    pulse_start(32'h0000_1000, 16'd192);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(req_valid_o), 64'd0);
    chk("rst_busy",  64'(busy_o), 64'd0);
    chk("rst_done",  64'(done_o), 64'd0);
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done_o !== 1'b0 || req_valid_o !== 1'b0) bad = 1'b1;
    end
    chk("rst_quiet", 64'(bad), 64'd0);
    chk("rst_bursts", 64'(bursts), 64'd1);
    exp_q.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
